reg_file: RTL and testbench

MIPS general-purpose register file for the single-cycle data path.
- Sits directly downstream of the write-back mux2 instances: the result mux drives the write data and the write-register mux drives the write address.
- Provides two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.

---
 rtl/reg_file.sv | 55 +++++
 tb/tb_reg_file.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS register file, two async read ports, one sync write port
// Optional write-through forwarding to the read ports: `define REGFILE_BYPASS_EN
module reg_file #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_active;

    assign wr_active = we3 && (wa3 != '0);

    // Entry 0 is cleared by reset but never written; reads of address 0 are forced to zero anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[wa3] <= wd3;
        end
    end

    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    assign stored1 = (ra1 == '0) ? '0 : regs[ra1];
    assign stored2 = (ra2 == '0) ? '0 : regs[ra2];

`ifdef REGFILE_BYPASS_EN
    // wr_active already excludes address 0, so a match here never forwards to ra==0.
    logic byp1;
    logic byp2;

    assign byp1 = !rst && wr_active && (ra1 == wa3);
    assign byp2 = !rst && wr_active && (ra2 == wa3);
    assign rd1  = byp1 ? wd3 : stored1;
    assign rd2  = byp2 ? wd3 : stored2;
`else
    assign rd1  = stored1;
    assign rd2  = stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int errors;
    int checks;
    logic [31:0] m [32];

    reg_file #(.WIDTH(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .we3 (we3),
        .wa3 (wa3),
        .wd3 (wd3),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
        if (a != 5'd0) m[a] = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        rst = 1'b1; we3 = 1'b0; wa3 = 5'd0; wd3 = 32'h0; ra1 = 5'd1; ra2 = 5'd31;
        tick();
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        rst = 1'b0;

        // 1. reset clears preloaded contents and drops the concurrent write
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'h12345678);
        ra1 = 5'd5; ra2 = 5'd31; #1;
        chk("preload_r5", rd1, 32'hDEADBEEF);
        chk("preload_r31", rd2, 32'h12345678);
        rst = 1'b1; we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hFFFFFFFF; #1;
        chk("rst_cycle_old_r5", rd1, 32'hDEADBEEF);
        tick();
        rst = 1'b0; we3 = 1'b0;
        m[5] = 32'h0; m[31] = 32'h0;
        chk("rst_clear_r5", rd1, 32'h0);
        chk("rst_clear_r31", rd2, 32'h0);

        // 2. basic write/read
        wr(5'd8, 32'hA5A5A5A5);
        wr(5'd9, 32'h00000001);
        wr(5'd12, 32'h0BADF00D);
        ra1 = 5'd8; ra2 = 5'd9; #1;
        chk("basic_r8", rd1, 32'hA5A5A5A5);
        chk("basic_r9", rd2, 32'h00000001);

        // 3. writes to register 0 are ignored, and forwarding never targets it
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0; #1;
        chk("r0_during_write_rd1", rd1, 32'h0);
        chk("r0_during_write_rd2", rd2, 32'h0);
        tick();
        we3 = 1'b0; #1;
        chk("r0_rd1", rd1, 32'h0);
        chk("r0_rd2", rd2, 32'h0);
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i); #1;
            chk($sformatf("r0_sweep_%0d", i), rd1, m[i]);
        end

        // 4. read during write to the same address
        wr(5'd10, 32'h11111111);
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h22222222; ra1 = 5'd10; ra2 = 5'd8; #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_before_edge", rd1, 32'h22222222);
`else
        chk("rdw_before_edge", rd1, 32'h11111111);
`endif
        chk("rdw_other_port", rd2, 32'hA5A5A5A5);
        tick();
        we3 = 1'b0; m[10] = 32'h22222222; #1;
        chk("rdw_after_edge", rd1, 32'h22222222);

        // 5. write enable low holds contents
        we3 = 1'b0; wa3 = 5'd12; wd3 = 32'hCAFEBABE; ra1 = 5'd12;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("we_low_cyc%0d", c), rd1, 32'h0BADF00D);
        end

        // 6. full sweep of pairs (i, 31-i)
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); #1;
            chk($sformatf("sweep_rd1_%0d", i), rd1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            chk($sformatf("sweep_rd2_%0d", 31 - i), rd2, (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
        end

        // mid-operation reset clears everything; forwarding is suppressed while rst is high
        rst = 1'b1; we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h77777777; ra1 = 5'd7; ra2 = 5'd20; #1;
        chk("midrst_no_bypass", rd1, 32'h107);
        tick();
        rst = 1'b0; we3 = 1'b0; #1;
        chk("midrst_r7", rd1, 32'h0);
        chk("midrst_r20", rd2, 32'h0);
        ra1 = 5'd31; ra2 = 5'd1; #1;
        chk("midrst_r31", rd1, 32'h0);
        chk("midrst_r1", rd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
